// File: rtl/simple_pipeline_pkg.sv
// rtl/simple_pipeline_pkg.sv - shared constants for the elastic arithmetic pipeline
package simple_pipeline_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int NUM_STAGES    = 3;
    localparam int OCC_W         = $clog2(NUM_STAGES + 1);
endpackage

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - per-stage valid register and ready/load handshake control
module pipe_stage_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic valid_prev,
    input  logic ready_next,
    output logic valid,
    output logic ready,
    output logic load
);
    logic valid_q;

    // An empty stage always accepts, so bubbles are squeezed out under a stall.
    assign ready = !valid_q | ready_next;
    assign load  = ready & valid_prev & !flush;
    assign valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (ready) begin
            valid_q <= valid_prev;
        end
    end
endmodule

// File: rtl/simple_pipeline_elastic.sv
// rtl/simple_pipeline_elastic.sv - flow-controlled 3-stage pipeline computing f = ((a+b)+(c-d))*d
module simple_pipeline_elastic
    import simple_pipeline_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int FULL_MUL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   f,
    output logic [OCC_W-1:0]     occupancy
);
    logic v1, v2, v3;
    logic r1, r2, r3;
    logic ld1, ld2, ld3;

    logic [WIDTH-1:0]   y1, y2, d1, y3, d2;
    logic [2*WIDTH-1:0] f_q;
    logic [2*WIDTH-1:0] prod;

    pipe_stage_ctrl u_s1 (.clk(clk), .rst_n(rst_n), .flush(flush), .valid_prev(in_valid),
                          .ready_next(r2), .valid(v1), .ready(r1), .load(ld1));
    pipe_stage_ctrl u_s2 (.clk(clk), .rst_n(rst_n), .flush(flush), .valid_prev(v1),
                          .ready_next(r3), .valid(v2), .ready(r2), .load(ld2));
    pipe_stage_ctrl u_s3 (.clk(clk), .rst_n(rst_n), .flush(flush), .valid_prev(v2),
                          .ready_next(out_ready), .valid(v3), .ready(r3), .load(ld3));

    // rst_n gates in_ready so a producer never sees a handshake land in reset.
    assign in_ready  = r1 & !flush & rst_n;
    assign out_valid = v3;
    assign f         = f_q;
    assign occupancy = OCC_W'(v1) + OCC_W'(v2) + OCC_W'(v3);

    assign prod = {{WIDTH{1'b0}}, y3} * {{WIDTH{1'b0}}, d2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1  <= '0;
            y2  <= '0;
            d1  <= '0;
            y3  <= '0;
            d2  <= '0;
            f_q <= '0;
        end else begin
            if (ld1) begin
                y1 <= a + b;
                y2 <= c - d;
                d1 <= d;
            end
            if (ld2) begin
                y3 <= y1 + y2;
                d2 <= d1;
            end
            if (ld3) begin
                f_q <= (FULL_MUL != 0) ? prod : {{WIDTH{1'b0}}, prod[WIDTH-1:0]};
            end
        end
    end
endmodule

// File: tb/tb_simple_pipeline_elastic.sv
// tb/tb_simple_pipeline_elastic.sv - randomized self-checking bench with queue-based reference model
module tb_simple_pipeline_elastic;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [7:0]  a, b, c, d;
    logic        in_ready, out_valid, in_ready0, out_valid0;
    logic [15:0] f, f0;
    logic [1:0]  occupancy, occupancy0;

    int checks = 0;
    int passes = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] got0_q[$];
    bit          last_acc;
    bit          hold_prev;
    logic [15:0] f_prev;

    always #5 clk = ~clk;

    simple_pipeline_elastic #(.WIDTH(8), .FULL_MUL(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .occupancy(occupancy));

    simple_pipeline_elastic #(.WIDTH(8), .FULL_MUL(0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid0), .out_ready(out_ready),
        .f(f0), .occupancy(occupancy0));

    function automatic logic [15:0] ref_f(int ia, int ib, int ic, int id);
        int y1, y2, y3;
        y1 = (ia + ib) % 256;
        y2 = (ic - id + 256) % 256;
        y3 = (y1 + y2) % 256;
        return 16'(y3 * id);
    endfunction

    // Advance one clock, recording both handshakes seen just before the edge.
    task automatic step();
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (last_acc) exp_q.push_back(ref_f(a, b, c, d));
        if (out_valid && out_ready) begin
            got_q.push_back(f);
            got0_q.push_back(f0);
        end
        hold_prev = out_valid && !out_ready;
        f_prev = f;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    endtask

    task automatic clear_q();
        exp_q.delete(); got_q.delete(); got0_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
        a = 0; b = 0; c = 0; d = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0d want 0", out_valid); else passes++;
        checks++; if (f !== 16'd0) $display("FAIL reset_f got %0d want 0", f); else passes++;
        checks++; if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0d want 0", in_ready); else passes++;
        rst_n = 1;
        in_valid = 1; a = 1; b = 2; c = 5; d = 3;
        repeat (4) step();
        checks++; if (occupancy !== 2'd3) $display("FAIL prefill_occ got %0d want 3", occupancy); else passes++;
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got %0d want 0", out_valid); else passes++;
        checks++; if (f !== 16'd0) $display("FAIL midreset_f got %0d want 0", f); else passes++;
        checks++; if (occupancy !== 2'd0) $display("FAIL midreset_occ got %0d want 0", occupancy); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL midreset_in_ready got %0d want 0", in_ready); else passes++;
        @(posedge clk);
        #1;
        rst_n = 1; in_valid = 0;
        step();
        checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %0d want 1", in_ready); else passes++;
        clear_q();
    endtask

    task automatic test_vectors();
        logic [7:0]  va[2] = '{8'd1, 8'd200};
        logic [7:0]  vb[2] = '{8'd2, 8'd100};
        logic [7:0]  vc[2] = '{8'd5, 8'd10};
        logic [7:0]  vd[2] = '{8'd3, 8'd20};
        logic [15:0] ef[2] = '{16'd15, 16'd680};
        logic [15:0] ef0[2] = '{16'd15, 16'd168};
        for (int i = 0; i < 2; i++) begin
            a = va[i]; b = vb[i]; c = vc[i]; d = vd[i];
            in_valid = 1; out_ready = 1;
            step();
            checks++; if (last_acc !== 1'b1) $display("FAIL vec%0d_accept got %0d want 1", i, last_acc); else passes++;
            in_valid = 0;
            step();
            checks++; if (out_valid !== 1'b0) $display("FAIL vec%0d_early got %0d want 0", i, out_valid); else passes++;
            step();
            checks++; if (out_valid !== 1'b1) $display("FAIL vec%0d_latency got %0d want 1", i, out_valid); else passes++;
            checks++; if (f !== ef[i]) $display("FAIL vec%0d_f got %0d want %0d", i, f, ef[i]); else passes++;
            checks++; if (f0 !== ef0[i]) $display("FAIL vec%0d_f_legacy got %0d want %0d", i, f0, ef0[i]); else passes++;
            step();
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        logic [7:0] ops[5][4];
        int idx = 0;
        int n;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4; j++) ops[i][j] = 8'($urandom);
        out_ready = 0;
        repeat (6) begin
            in_valid = (idx < 5);
            if (idx < 5) begin a = ops[idx][0]; b = ops[idx][1]; c = ops[idx][2]; d = ops[idx][3]; end
            step();
            if (last_acc) idx++;
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || f !== f_prev)
                    $display("FAIL bp_hold got v=%0d f=%0d want v=1 f=%0d", out_valid, f, f_prev);
                else passes++;
            end
        end
        checks++; if (idx !== 3) $display("FAIL bp_accepted got %0d want 3", idx); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %0d want 0", in_ready); else passes++;
        checks++; if (occupancy !== 2'd3) $display("FAIL bp_occ got %0d want 3", occupancy); else passes++;
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_simul_ready got %0d want 1", in_ready); else passes++;
        step();
        if (last_acc) idx++;
        checks++; if (occupancy !== 2'd3) $display("FAIL bp_simul_occ got %0d want 3", occupancy); else passes++;
        for (int k = 0; k < 40 && got_q.size() < 5; k++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin a = ops[idx][0]; b = ops[idx][1]; c = ops[idx][2]; d = ops[idx][3]; end
            step();
            if (last_acc) idx++;
        end
        in_valid = 0;
        n = got_q.size();
        checks++; if (n !== 5 || exp_q.size() !== 5) $display("FAIL bp_count got %0d want 5", n); else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [15:0] e, g, g0;
            e = exp_q.pop_front(); g = got_q.pop_front(); g0 = got0_q.pop_front();
            checks++; if (g !== e) $display("FAIL bp_f got %0d want %0d", g, e); else passes++;
            checks++; if (g0 !== (e & 16'h00ff)) $display("FAIL bp_f_legacy got %0d want %0d", g0, e & 16'h00ff); else passes++;
        end
        clear_q();
    endtask

    task automatic test_bubbles();
        int idx = 0;
        int n;
        for (int cyc = 0; cyc < 100 && got_q.size() < 8; cyc++) begin
            in_valid = (cyc % 2 == 0) && (idx < 8);
            out_ready = !(cyc == 4 || cyc == 5);
            rand_ops();
            step();
            if (last_acc) idx++;
            checks++;
            if (occupancy !== 2'(exp_q.size() - got_q.size()))
                $display("FAIL bub_occ got %0d want %0d", occupancy, exp_q.size() - got_q.size());
            else passes++;
        end
        in_valid = 0;
        n = got_q.size();
        checks++; if (n !== 8 || exp_q.size() !== 8) $display("FAIL bub_count got %0d want 8", n); else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [15:0] e, g, g0;
            e = exp_q.pop_front(); g = got_q.pop_front(); g0 = got0_q.pop_front();
            checks++; if (g !== e) $display("FAIL bub_f got %0d want %0d", g, e); else passes++;
            checks++; if (g0 !== (e & 16'h00ff)) $display("FAIL bub_f_legacy got %0d want %0d", g0, e & 16'h00ff); else passes++;
        end
        clear_q();
    endtask

    task automatic test_flush();
        int acc = 0;
        int n;
        out_ready = 0;
        for (int k = 0; k < 10 && acc < 3; k++) begin
            in_valid = 1; rand_ops();
            step();
            if (last_acc) acc++;
        end
        checks++; if (occupancy !== 2'd3) $display("FAIL fl_pre_occ got %0d want 3", occupancy); else passes++;
        flush = 1; in_valid = 1; rand_ops();
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL fl_in_ready got %0d want 0", in_ready); else passes++;
        step();
        flush = 0; in_valid = 0;
        checks++; if (occupancy !== 2'd0) $display("FAIL fl_occ got %0d want 0", occupancy); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL fl_out_valid got %0d want 0", out_valid); else passes++;
        clear_q();
        out_ready = 1; in_valid = 1; a = 1; b = 2; c = 5; d = 3;
        step();
        in_valid = 0;
        for (int k = 0; k < 10 && got_q.size() < 1; k++) step();
        n = got_q.size();
        checks++; if (n !== 1) $display("FAIL fl_after_count got %0d want 1", n); else passes++;
        if (n > 0) begin
            checks++; if (got_q[0] !== 16'd15) $display("FAIL fl_after_f got %0d want 15", got_q[0]); else passes++;
        end
        clear_q();
    endtask

    task automatic test_random();
        int n, m;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid = ($urandom % 3) != 0;
            out_ready = ($urandom % 2) != 0;
            rand_ops();
            step();
            checks++;
            if (occupancy !== 2'(exp_q.size() - got_q.size()))
                $display("FAIL rnd_occ got %0d want %0d", occupancy, exp_q.size() - got_q.size());
            else passes++;
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || f !== f_prev)
                    $display("FAIL rnd_hold got v=%0d f=%0d want v=1 f=%0d", out_valid, f, f_prev);
                else passes++;
            end
            checks++;
            if (out_valid0 !== out_valid || in_ready0 !== in_ready || occupancy0 !== occupancy)
                $display("FAIL rnd_legacy_ctrl got %0d%0d%0d want %0d%0d%0d",
                         out_valid0, in_ready0, occupancy0, out_valid, in_ready, occupancy);
            else passes++;
        end
        in_valid = 0; out_ready = 1;
        m = exp_q.size();
        for (int k = 0; k < 10 && got_q.size() < m; k++) step();
        n = got_q.size();
        checks++; if (n !== m) $display("FAIL rnd_count got %0d want %0d", n, m); else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [15:0] e, g, g0;
            e = exp_q.pop_front(); g = got_q.pop_front(); g0 = got0_q.pop_front();
            checks++; if (g !== e) $display("FAIL rnd_f got %0d want %0d", g, e); else passes++;
            checks++; if (g0 !== (e & 16'h00ff)) $display("FAIL rnd_f_legacy got %0d want %0d", g0, e & 16'h00ff); else passes++;
        end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_bubbles();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
